stream_downsizer: RTL and testbench
===================================

# stream_downsizer

Width-converting stage directly downstream of the synchronous FIFO. It pops one DATA_WIDTH word from the FIFO master port and emits it as DATA_WIDTH/OUT_WIDTH narrow slices, least-significant slice first, on a valid/ready master port. Full throughput is one slice per cycle: the next word loads in the same cycle the last slice of the current word is accepted.

## Interface
- DATA_WIDTH, 32, input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output slice width.
- SLICES, DATA_WIDTH/OUT_WIDTH (derived localparam), slices per word; must be ≥2.
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_valid_s  in  1  upstream word valid; driven by FIFO o_valid_m.
- o_ready_s  out  1  word accept; drives FIFO i_ready_m.
- i_datain  in  DATA_WIDTH  word; driven by FIFO o_dataout.
- o_valid_m  out  1  slice valid.
- i_ready_m  in  1  downstream slice accept.
- o_dataout  out  OUT_WIDTH  current slice.
- o_last  out  1  current slice is the final slice of its word.
- o_busy  out  1  a word is held (o_valid_m mirror, registered state).

## Operation
- States: EMPTY (no word held) and DRAIN (word held, slice index idx in 0..SLICES-1).
- Word handshake: i_valid_s && o_ready_s. Slice handshake: o_valid_m && i_ready_m.
- o_ready_s = EMPTY || (DRAIN && idx==SLICES-1 && i_ready_m). This is combinational from i_ready_m.
- EMPTY + word handshake -> DRAIN, register word, idx=0.
- DRAIN + slice handshake, idx<SLICES-1 -> idx+1.
- DRAIN + slice handshake, idx==SLICES-1:
  - If i_valid_s: load the new word, idx=0, stay in DRAIN (zero bubble).
  - Else: -> EMPTY.
- o_dataout = word[idx*OUT_WIDTH +: OUT_WIDTH]. o_last = (idx==SLICES-1).
- Held word and idx are stable while i_ready_m=0 (AXI-style: once valid is asserted, data is not withdrawn).
- idx width is $clog2(SLICES). It never wraps past SLICES-1.

## Timing
- Reset values: o_valid_m=0, o_last=0, o_busy=0, o_dataout=0. o_ready_s=1 (EMPTY).
- Latency: word accepted at edge N, first slice valid in the cycle after edge N.
- Steady state: SLICES output cycles per word, no idle cycles between words.
- Reset asserted mid-word: the partial word is discarded and state returns to EMPTY on that edge. No slice completes in a reset cycle.
- Simultaneous last-slice accept and new word: both handshakes complete on the same edge.
- i_valid_s while DRAIN and not on the last slice: ignored (o_ready_s=0), so the FIFO holds its word.

## Configuration
- STREAM_DOWNSIZER_PARITY_EN defined: adds port o_parity (out, 1).
  - It is the even parity (XOR reduction) of o_dataout.
  - It is valid with o_valid_m and resets to 0.
- Macro undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package stream_pkg holds:
  - the state enum typedef (EMPTY, DRAIN);
  - a function computing slice count, with the divisibility check made an elaboration-time error.
- Sub-module: stream_parity_gen (combinational XOR reduce, OUT_WIDTH param). It is instantiated only under STREAM_DOWNSIZER_PARITY_EN.

## Test plan
- Single word, default params: push 0x11223344, i_ready_m=1.
  - Expected: slices 0x44, 0x33, 0x22, 0x11 on consecutive cycles, o_last only on 0x11, then o_valid_m=0.
- Back-to-back: words 0xA1B2C3D4 and 0x01020304, i_valid_s held high.
  - Expected: 8 consecutive slices D4, C3, B2, A1, 04, 03, 02, 01, no gap.
  - o_ready_s pulses only on the A1 and 01 cycles.
- Backpressure: i_ready_m=0 for 3 cycles after slice 0x33.
  - Expected: o_dataout holds 0x33 and o_valid_m stays 1.
  - Resumes with 0x22. The FIFO sees o_ready_s=0 throughout.
- Reset mid-word: assert i_rst after slice 0x44 of 0x11223344.
  - Expected: next cycle o_valid_m=0, o_ready_s=1.
  - A new word 0xDEADBEEF then emits EF first.
- FIFO integration (depth 8): write 8 words to full, then i_ready_m=1.
  - Expected: 32 slices in order, FIFO o_empty asserted after the 8th word pop, no data loss.
- Parity build: 0x07 -> o_parity=1; 0x03 -> o_parity=0.
  - Port absent when the macro is undefined.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and elaboration helpers for the stream width-conversion blocks.
package stream_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Returns 0 when the word width does not divide into whole slices, so the
    // instantiating module can reject the parameter set at elaboration.
    function automatic int calc_slices(input int data_width, input int out_width);
        if (out_width <= 0) return 0;
        if ((data_width % out_width) != 0) return 0;
        return data_width / out_width;
    endfunction

endpackage

// File: rtl/stream_parity_gen.sv
// Combinational even-parity (XOR reduction) of one output slice.
module stream_parity_gen #(
    parameter int OUT_WIDTH = 8
) (
    input  logic [OUT_WIDTH-1:0] i_data,
    output logic                 o_parity
);

    assign o_parity = ^i_data;

endmodule

// File: rtl/stream_downsizer.sv
// Splits each DATA_WIDTH word into OUT_WIDTH slices, LS slice first, at one slice per cycle.
// Optional STREAM_DOWNSIZER_PARITY_EN adds o_parity, the XOR reduction of o_dataout.
module stream_downsizer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid_s,
    output logic                  o_ready_s,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_valid_m,
    input  logic                  i_ready_m,
    output logic [OUT_WIDTH-1:0]  o_dataout,
    output logic                  o_last,
`ifdef STREAM_DOWNSIZER_PARITY_EN
    output logic                  o_parity,
`endif
    output logic                  o_busy
);

    localparam int SLICES = calc_slices(DATA_WIDTH, OUT_WIDTH);
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    generate
        if (SLICES < 2) begin : g_bad_params
            $error("stream_downsizer: DATA_WIDTH must be a multiple of OUT_WIDTH giving at least 2 slices");
        end
    endgenerate

    state_e                             state_q;
    logic [SLICES-1:0][OUT_WIDTH-1:0]   word_q;
    logic [IDX_W-1:0]                   idx_q;
    logic [IDX_W-1:0]                   idx_d;
    logic                               on_last;

    assign on_last = (idx_q == LAST_IDX);
    assign idx_d   = idx_q + IDX_W'(1);

    // Ready for a new word is combinational from i_ready_m so the next word can
    // load on the same edge that retires the final slice (no bubble).
    assign o_ready_s = (state_q == EMPTY) || ((state_q == DRAIN) && on_last && i_ready_m);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY;
            word_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (i_valid_s) begin
                        word_q  <= i_datain;
                        idx_q   <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_ready_m) begin
                        if (!on_last) begin
                            idx_q <= idx_d;
                        end else if (i_valid_s) begin
                            word_q <= i_datain;
                            idx_q  <= '0;
                        end else begin
                            // idx parks at 0 so o_last stays low while empty
                            idx_q   <= '0;
                            state_q <= EMPTY;
                        end
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign o_valid_m = (state_q == DRAIN);
    assign o_busy    = (state_q == DRAIN);
    assign o_dataout = word_q[idx_q];
    assign o_last    = on_last;

`ifdef STREAM_DOWNSIZER_PARITY_EN
    stream_parity_gen #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_parity (
        .i_data   (o_dataout),
        .o_parity (o_parity)
    );
`endif

endmodule

// File: tb/tb_stream_downsizer.sv
// Scoreboard bench for stream_downsizer: word source queue, slice expectations queue, negedge monitor.
module tb_stream_downsizer;

    logic        clk;
    logic        rst;
    logic        i_valid_s;
    logic        o_ready_s;
    logic [31:0] i_datain;
    logic        o_valid_m;
    logic        i_ready_m;
    logic [7:0]  o_dataout;
    logic        o_last;
    logic        o_busy;
`ifdef STREAM_DOWNSIZER_PARITY_EN
    logic        o_parity;
`endif

    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int slice_cnt = 0;

    logic [31:0] src_q[$];
    logic [8:0]  exp_q[$];
    logic        word_hs_seen = 1'b0;

    stream_downsizer #(
        .DATA_WIDTH (32),
        .OUT_WIDTH  (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid_s (i_valid_s),
        .o_ready_s (o_ready_s),
        .i_datain  (i_datain),
        .o_valid_m (o_valid_m),
        .i_ready_m (i_ready_m),
        .o_dataout (o_dataout),
        .o_last    (o_last),
`ifdef STREAM_DOWNSIZER_PARITY_EN
        .o_parity  (o_parity),
`endif
        .o_busy    (o_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // driver: expected slices come from the bench's own split of the word
    task automatic push_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        src_q.push_back(w);
        for (int s = 0; s < 4; s++) begin
            exp_q.push_back({(s == 3), tmp[8*s +: 8]});
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_valid_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, o_valid_m}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    // word source modelling the upstream FIFO read port
    always @(posedge clk) begin
        #1;
        if (word_hs_seen && src_q.size() > 0) src_q.delete(0);
        i_valid_s = (src_q.size() > 0);
        i_datain  = (src_q.size() > 0) ? src_q[0] : 32'd0;
    end

    // monitor: handshakes are sampled mid-cycle, completing on the next rising edge
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            word_hs_seen = 1'b0;
        end else begin
            word_hs_seen = i_valid_s && o_ready_s;
            if (o_valid_m && i_ready_m) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_slice: got %h expected none", o_dataout);
                end else begin
                    e = exp_q.pop_front();
                    check("slice_data", {24'd0, o_dataout}, {24'd0, e[7:0]});
                    check("slice_last", {31'd0, o_last}, {31'd0, e[8]});
                    check("ready_on_last", {31'd0, o_ready_s}, {31'd0, e[8]});
`ifdef STREAM_DOWNSIZER_PARITY_EN
                    check("parity", {31'd0, o_parity}, {31'd0, ^e[7:0]});
`endif
                    slice_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst       = 1'b1;
        i_ready_m = 1'b0;
        i_valid_s = 1'b0;
        i_datain  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, o_valid_m}, 32'd0);
        check("rst_last",  {31'd0, o_last},    32'd0);
        check("rst_busy",  {31'd0, o_busy},    32'd0);
        check("rst_data",  {24'd0, o_dataout}, 32'd0);
        check("rst_ready", {31'd0, o_ready_s}, 32'd1);
        @(posedge clk); #1;
        rst       = 1'b0;
        i_ready_m = 1'b1;

        // single word
        push_word(32'h11223344);
        wait_valid("single_first_valid");
        check("single_first_data", {24'd0, o_dataout}, 32'h44);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("single_no_gap", {31'd0, o_valid_m}, 32'd1);
        end
        @(negedge clk);
        check("single_idle_after", {31'd0, o_valid_m}, 32'd0);
        wait_drain("single_drain");

        // back-to-back words, zero bubble
        push_word(32'hA1B2C3D4);
        push_word(32'h01020304);
        wait_valid("b2b_first_valid");
        check("b2b_first_data", {24'd0, o_dataout}, 32'hD4);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("b2b_no_gap", {31'd0, o_valid_m}, 32'd1);
        end
        @(negedge clk);
        check("b2b_idle_after", {31'd0, o_valid_m}, 32'd0);
        wait_drain("b2b_drain");

        // backpressure holding slice 0x33 with a second word pending upstream
        push_word(32'h11223344);
        push_word(32'h55667788);
        wait_valid("bp_first_valid");
        @(posedge clk); #1;
        i_ready_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, o_valid_m}, 32'd1);
            check("bp_hold_data",  {24'd0, o_dataout}, 32'h33);
            check("bp_ready_s",    {31'd0, o_ready_s}, 32'd0);
        end
        @(posedge clk); #1;
        i_ready_m = 1'b1;
        @(negedge clk);
        check("bp_resume_data", {24'd0, o_dataout}, 32'h33);
        @(negedge clk);
        check("bp_next_data", {24'd0, o_dataout}, 32'h22);
        wait_drain("bp_drain");

        // reset mid-word: remaining slices of the partial word are discarded
        push_word(32'h11223344);
        wait_valid("rst_mid_first_valid");
        check("rst_mid_first_data", {24'd0, o_dataout}, 32'h44);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, o_valid_m}, 32'd0);
        check("rst_mid_ready", {31'd0, o_ready_s}, 32'd1);
        check("rst_mid_discard", exp_q.size(), 32'd3);
        exp_q.delete();
        push_word(32'hDEADBEEF);
        wait_valid("rst_new_valid");
        check("rst_new_first", {24'd0, o_dataout}, 32'hEF);
        wait_drain("rst_new_drain");

        // FIFO integration: 8 words queued while the sink stalls
        i_ready_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            base = 4 * i + 16;
            push_word({8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)});
        end
        repeat (5) @(negedge clk);
        check("fifo_one_taken", src_q.size(), 32'd7);
        check("fifo_ready_low", {31'd0, o_ready_s}, 32'd0);
        base = slice_cnt;
        @(posedge clk); #1;
        i_ready_m = 1'b1;
        wait_drain("fifo_drain");
        check("fifo_src_empty", src_q.size(), 32'd0);
        check("fifo_slice_count", 32'(slice_cnt - base), 32'd32);

        // parity patterns: slices 07, 03, 00, 00
        push_word(32'h00000307);
        wait_valid("par_first_valid");
`ifdef STREAM_DOWNSIZER_PARITY_EN
        check("par_07", {31'd0, o_parity}, 32'd1);
        @(negedge clk);
        check("par_03", {31'd0, o_parity}, 32'd0);
`endif
        wait_drain("par_drain");

        repeat (3) @(negedge clk);
        check("final_idle", {31'd0, o_busy}, 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
